piso: RTL and testbench
=======================

Name: piso

Overview:
- Parameterised parallel-in, serial-out shift register. A parallel word is captured on a load strobe, then shifted out one bit per clock on a single serial line.
- Sits between a parallel data source and a 1-bit serial sink.
- Adds framing status outputs (valid, last, busy) so downstream logic can qualify the serial stream.

Parameters:
- WIDTH, 4, parallel word width in bits; legal range 2..64.
- MSB_FIRST, 1, 1 = shift out din[WIDTH-1] first; 0 = shift out din[0] first.
- FILL_BIT, 1'b0, value shifted into the vacated end of the register on each shift.

Ports:
- clk  input  1  rising-edge clock; all state changes occur on its rising edge, except reset.
- rst  input  1  asynchronous, active-low reset; asserting it (low) clears all state immediately.
- load  input  1  synchronous parallel-load strobe, sampled on the rising clk edge.
- din  input  WIDTH  parallel data word, captured when load=1.
- dout  output  1  serial data out; combinational from the output-end bit of the shift register.
- dout_valid  output  1  high while dout carries a bit of the most recently loaded word.
- last  output  1  high while dout carries the final bit of the loaded word.
- busy  output  1  identical to dout_valid; provided for handshake convenience.

Behaviour:
- State:
  - shift register sreg[WIDTH-1:0]
  - bit counter cnt, width clog2(WIDTH+1)
- Reset (rst=0, asynchronous):
  - sreg=0, cnt=0
  - dout=0, dout_valid=0, last=0, busy=0
  - Outputs hold these values while rst=0, regardless of clk, load or din.
  - Reset deassertion is used synchronously by the design; there is no recovery cycle. The first rising edge with rst=1 acts normally.
- Each rising edge with rst=1, in priority order:
  1. load=1: sreg<=din; cnt<=WIDTH. Load wins over shifting and restarts any frame in progress; the remaining bits of the old word are discarded.
  2. Otherwise:
     - MSB_FIRST=1: sreg<={sreg[WIDTH-2:0],FILL_BIT}.
     - MSB_FIRST=0: sreg<={FILL_BIT,sreg[WIDTH-1:1]}.
     - cnt<=cnt-1 if cnt>0; cnt saturates at 0.
- Shifting runs every non-load cycle, including when idle; it is harmless because FILL_BIT fills the register.
- dout = sreg[WIDTH-1] if MSB_FIRST else sreg[0].
  - Latency: first serial bit is visible immediately after the loading edge (0 cycles).
  - Bit k (k=0..WIDTH-1) is visible after the k-th subsequent edge.
- dout_valid = busy = (cnt!=0); last = (cnt==1). All three are combinational from cnt.
- Boundary cases:
  - load held high for N cycles: reloads every edge; dout stays at the first bit of din; cnt stays WIDTH.
  - After the last bit: dout shows FILL_BIT and dout_valid=0. Consumers must qualify dout with dout_valid.
  - Reset mid-frame: the frame is aborted immediately; no bits are output after reset releases.
  - din changes while load=0: no effect.

Test Plan:
- Reset: rst=0 with load=1, din=4'b1111, clk toggling -> dout=0, dout_valid=0, last=0, busy=0 throughout.
- Basic MSB-first frame: release rst; one-cycle load with din=4'b1100, then load=0 -> dout sequence 1,1,0,0 on consecutive cycles starting after the load edge; dout_valid high for exactly 4 cycles; last high only on the 4th bit; then dout=0, dout_valid=0.
- LSB-first (MSB_FIRST=0): load din=4'b1101 -> dout sequence 1,0,1,1; fill value follows.
- Reload mid-frame: load 4'b1010, shift 2 bits (1,0), then load 4'b0111 -> dout continues 0,1,1,1 with cnt restarted; last asserts on the final bit of the new word only.
- Held load: load=1 for 3 cycles with din=4'b1000 -> dout=1 and dout_valid=1 all 3 cycles; after release, dout sequence 1,0,0,0 completes normally.
- Async reset mid-frame: assert rst=0 between clock edges during the 2nd bit -> all outputs go to 0 before the next edge; after release, dout=0 and dout_valid=0 until the next load.

Source files
------------

// File: rtl/piso.sv
// Parallel-in, serial-out shift register with framing status.
// A word is captured on load and shifted out one bit per clock; valid/last/busy qualify the stream.
module piso #(
  parameter int       WIDTH     = 4,
  parameter bit       MSB_FIRST = 1'b1,
  parameter logic     FILL_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             dout,
  output logic             dout_valid,
  output logic             last,
  output logic             busy
);

  localparam int             CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(WIDTH);

  logic [WIDTH-1:0] r_sreg;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_shifted;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_out_bit;
  logic             w_active;

  // Vacated end takes FILL_BIT, so shifting while idle is harmless.
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_shifted = {r_sreg[WIDTH-2:0], FILL_BIT};
      assign w_out_bit = r_sreg[WIDTH-1];
    end else begin : g_lsb
      assign w_shifted = {FILL_BIT, r_sreg[WIDTH-1:1]};
      assign w_out_bit = r_sreg[0];
    end
  endgenerate

  always_comb begin
    w_cnt_next = r_cnt;
    if (r_cnt != '0) begin
      w_cnt_next = r_cnt - 1'b1;
    end
  end

  // Load has priority and restarts any frame in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (load) begin
      r_sreg <= din;
      r_cnt  <= LOAD_CNT;
    end else begin
      r_sreg <= w_shifted;
      r_cnt  <= w_cnt_next;
    end
  end

  assign w_active   = (r_cnt != '0);
  assign dout       = w_out_bit;
  assign dout_valid = w_active;
  assign busy       = w_active;
  assign last       = (r_cnt == CNT_W'(1));

endmodule

// File: tb/tb_piso.sv
// Directed bench for piso: table-driven MSB-first vectors plus hand sequences
// for LSB-first order, FILL_BIT=1 and asynchronous reset mid-frame.
module tb_piso;

  logic       clk = 1'b0;
  logic       rst;
  logic       load, l_load;
  logic [3:0] din, l_din;

  logic m_dout, m_vld, m_last, m_busy;
  logic l_dout, l_vld, l_last, l_busy;
  logic f_dout, f_vld, f_last, f_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  piso #(.WIDTH(4), .MSB_FIRST(1'b1), .FILL_BIT(1'b0)) u_msb (
    .clk(clk), .rst(rst), .load(load), .din(din),
    .dout(m_dout), .dout_valid(m_vld), .last(m_last), .busy(m_busy)
  );

  piso #(.WIDTH(4), .MSB_FIRST(1'b0), .FILL_BIT(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .load(l_load), .din(l_din),
    .dout(l_dout), .dout_valid(l_vld), .last(l_last), .busy(l_busy)
  );

  piso #(.WIDTH(4), .MSB_FIRST(1'b1), .FILL_BIT(1'b1)) u_fill (
    .clk(clk), .rst(rst), .load(l_load), .din(l_din),
    .dout(f_dout), .dout_valid(f_vld), .last(f_last), .busy(f_busy)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       load;
    logic [3:0] din;
    logic [2:0] exp;   // {dout, dout_valid, last}; busy must equal dout_valid
  } vec_t;

  vec_t vt[26];

  function automatic vec_t mk(string n, logic r, logic ld, logic [3:0] d, logic [2:0] e);
    vec_t v;
    v.name = n; v.rst = r; v.load = ld; v.din = d; v.exp = e;
    return v;
  endfunction

  task automatic check(string name, logic [3:0] act, logic [2:0] e);
    logic [3:0] req;
    req = {e, e[1]};
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got {dout,valid,last,busy}=%b required %b", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; load = 1'b1; din = 4'b1111;
    l_load = 1'b0; l_din = 4'b0000;

    vt[0]  = mk("rst_hold0",  1'b0, 1'b1, 4'b1111, 3'b000);
    vt[1]  = mk("rst_hold1",  1'b0, 1'b1, 4'b1111, 3'b000);
    // basic MSB-first frame 1100, din wiggles while idle
    vt[2]  = mk("b_load",     1'b1, 1'b1, 4'b1100, 3'b110);
    vt[3]  = mk("b_bit1",     1'b1, 1'b0, 4'b1111, 3'b110);
    vt[4]  = mk("b_bit2",     1'b1, 1'b0, 4'b0101, 3'b010);
    vt[5]  = mk("b_bit3",     1'b1, 1'b0, 4'b1111, 3'b011);
    vt[6]  = mk("b_done",     1'b1, 1'b0, 4'b1111, 3'b000);
    vt[7]  = mk("b_idle",     1'b1, 1'b0, 4'b1010, 3'b000);
    // reload mid-frame: 1010 for two bits, then 0111
    vt[8]  = mk("r_load1",    1'b1, 1'b1, 4'b1010, 3'b110);
    vt[9]  = mk("r_bit1",     1'b1, 1'b0, 4'b0000, 3'b010);
    vt[10] = mk("r_load2",    1'b1, 1'b1, 4'b0111, 3'b010);
    vt[11] = mk("r_bit1n",    1'b1, 1'b0, 4'b0000, 3'b110);
    vt[12] = mk("r_bit2n",    1'b1, 1'b0, 4'b0000, 3'b110);
    vt[13] = mk("r_bit3n",    1'b1, 1'b0, 4'b0000, 3'b111);
    vt[14] = mk("r_done",     1'b1, 1'b0, 4'b0000, 3'b000);
    // held load of 1000 for three edges
    vt[15] = mk("h_load0",    1'b1, 1'b1, 4'b1000, 3'b110);
    vt[16] = mk("h_load1",    1'b1, 1'b1, 4'b1000, 3'b110);
    vt[17] = mk("h_load2",    1'b1, 1'b1, 4'b1000, 3'b110);
    vt[18] = mk("h_bit1",     1'b1, 1'b0, 4'b0000, 3'b010);
    vt[19] = mk("h_bit2",     1'b1, 1'b0, 4'b0000, 3'b010);
    vt[20] = mk("h_bit3",     1'b1, 1'b0, 4'b0000, 3'b011);
    vt[21] = mk("h_done",     1'b1, 1'b0, 4'b0000, 3'b000);
    // all-ones word; counter saturates at zero afterwards
    vt[22] = mk("o_load",     1'b1, 1'b1, 4'b1111, 3'b110);
    vt[23] = mk("o_bit1",     1'b1, 1'b0, 4'b0000, 3'b110);
    vt[24] = mk("o_bit2",     1'b1, 1'b0, 4'b0000, 3'b110);
    vt[25] = mk("o_bit3",     1'b1, 1'b0, 4'b0000, 3'b111);

    #1;
    check("rst_initial", {m_dout, m_vld, m_last, m_busy}, 3'b000);

    for (int i = 0; i < 26; i++) begin
      rst  = vt[i].rst;
      load = vt[i].load;
      din  = vt[i].din;
      tick();
      check(vt[i].name, {m_dout, m_vld, m_last, m_busy}, vt[i].exp);
    end
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("o_sat", {m_dout, m_vld, m_last, m_busy}, 3'b000);
    end

    // LSB-first 1101 -> 1,0,1,1; FILL_BIT=1 MSB-first 1101 -> 1,1,0,1 then fill 1
    l_load = 1'b1; l_din = 4'b1101;
    tick();
    check("lsb_load",  {l_dout, l_vld, l_last, l_busy}, 3'b110);
    check("fill_load", {f_dout, f_vld, f_last, f_busy}, 3'b110);
    l_load = 1'b0; l_din = 4'b0000;
    tick();
    check("lsb_bit1",  {l_dout, l_vld, l_last, l_busy}, 3'b010);
    check("fill_bit1", {f_dout, f_vld, f_last, f_busy}, 3'b110);
    tick();
    check("lsb_bit2",  {l_dout, l_vld, l_last, l_busy}, 3'b110);
    check("fill_bit2", {f_dout, f_vld, f_last, f_busy}, 3'b010);
    tick();
    check("lsb_bit3",  {l_dout, l_vld, l_last, l_busy}, 3'b111);
    check("fill_bit3", {f_dout, f_vld, f_last, f_busy}, 3'b111);
    tick();
    check("lsb_done",  {l_dout, l_vld, l_last, l_busy}, 3'b000);
    check("fill_done", {f_dout, f_vld, f_last, f_busy}, 3'b100);

    // asynchronous reset during the second bit of an MSB-first frame
    load = 1'b1; din = 4'b1100;
    tick();
    check("a_load", {m_dout, m_vld, m_last, m_busy}, 3'b110);
    load = 1'b0;
    tick();
    check("a_bit1", {m_dout, m_vld, m_last, m_busy}, 3'b110);
    #2;
    rst = 1'b0;
    #1;
    check("a_async", {m_dout, m_vld, m_last, m_busy}, 3'b000);
    tick();
    check("a_held", {m_dout, m_vld, m_last, m_busy}, 3'b000);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("a_after", {m_dout, m_vld, m_last, m_busy}, 3'b000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
